conf_int_dot_seq: RTL and testbench

CONF_INT_DOT_SEQ -- requirements
Module: conf_int_dot_seq

---
 rtl/conf_int_pkg.sv | 11 +
 rtl/conf_int_skid2.sv | 68 ++++++
 rtl/conf_int_dot_seq.sv | 108 ++++++++++
 tb/tb_conf_int_dot_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conf_int_pkg.sv
// Shared definitions for the integer dot-product sequencer: FSM encoding and default widths.
package conf_int_pkg;
    localparam int DEF_DATA_PATH_BITWIDTH = 16;
    localparam int DEF_LEN_W              = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/conf_int_skid2.sv
// Two-entry skid buffer for the operand stream; ready comes straight from a flop.
module conf_int_skid2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b
);
    logic [W-1:0] mem_a [2];
    logic [W-1:0] mem_b [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic [1:0]   count_next;
    logic         ready_reg;
    logic         push;
    logic         pop;

    assign push      = in_valid && ready_reg;
    assign out_valid = (count_reg != 2'd0);
    assign pop       = out_valid && out_ready;
    assign in_ready  = ready_reg;
    assign out_a     = mem_a[rd_ptr_reg];
    assign out_b     = mem_b[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + 2'd1;
        else if (pop && !push)
            count_next = count_reg - 2'd1;
    end

    // Ready is precomputed from the next occupancy so it never depends on in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
            ready_reg  <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_next;
            ready_reg <= (count_next != 2'd2);
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == gi[0])) begin
                    mem_a[gi] <= in_a;
                    mem_b[gi] <= in_b;
                end
            end
        end
    endgenerate
endmodule

// File: rtl/conf_int_dot_seq.sv
// Sequential dot product around an external combinational MAC (d = a*b + c).
// Optional 2-entry operand skid buffer enabled by defining CONF_INT_DOT_SEQ_SKID_EN.
module conf_int_dot_seq
    import conf_int_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH,
    parameter int LEN_W              = DEF_LEN_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LEN_W-1:0]              len,
    input  logic [DATA_PATH_BITWIDTH-1:0] init_acc,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
    output logic [DATA_PATH_BITWIDTH-1:0] mac_a,
    output logic [DATA_PATH_BITWIDTH-1:0] mac_b,
    output logic [DATA_PATH_BITWIDTH-1:0] mac_c,
    input  logic [DATA_PATH_BITWIDTH-1:0] mac_d,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] out_data,
    output logic                          busy
);
    state_t                        state_reg, state_next;
    logic [DATA_PATH_BITWIDTH-1:0] acc_reg, acc_next;
    logic [LEN_W-1:0]              cnt_reg, cnt_next;
    logic                          head_valid;
    logic [DATA_PATH_BITWIDTH-1:0] head_a;
    logic [DATA_PATH_BITWIDTH-1:0] head_b;
    logic                          consume;
    logic                          beat;

    assign consume = (state_reg == ST_RUN);
    assign beat    = head_valid && consume;

`ifdef CONF_INT_DOT_SEQ_SKID_EN
    conf_int_skid2 #(
        .W(DATA_PATH_BITWIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (head_valid),
        .out_ready (consume),
        .out_a     (head_a),
        .out_b     (head_b)
    );
`else
    assign in_ready   = consume;
    assign head_valid = in_valid;
    assign head_a     = in_a;
    assign head_b     = in_b;
`endif

    // The MAC path is purely combinational: head operands and acc go out, mac_d lands in acc.
    assign mac_a     = head_a;
    assign mac_b     = head_b;
    assign mac_c     = acc_reg;
    assign out_valid = (state_reg == ST_DONE);
    assign out_data  = acc_reg;
    assign busy      = (state_reg != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    acc_next   = init_acc;
                    cnt_next   = len;
                    state_next = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat) begin
                    acc_next = mac_d;
                    cnt_next = cnt_reg - LEN_W'(1);
                    if (cnt_reg == LEN_W'(1))
                        state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
        end
    end
endmodule

// File: tb/tb_conf_int_dot_seq.sv
// Directed + random bench for conf_int_dot_seq with a scoreboard of expected results.
// Also covers the CONF_INT_DOT_SEQ_SKID_EN build when that macro is defined.
module tb_conf_int_dot_seq;
    localparam int DW = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic [DW-1:0] init_acc;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a, in_b;
    logic [DW-1:0] mac_a, mac_b, mac_c, mac_d;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] ja[8];
    logic [DW-1:0] jb[8];

    always #5 clk = ~clk;

    // External combinational MAC, wrapping at DW bits
    assign mac_d = DW'(mac_a * mac_b + mac_c);

    conf_int_dot_seq #(
        .DATA_PATH_BITWIDTH(DW),
        .LEN_W(LW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .init_acc(init_acc),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_d(mac_d),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_expected(input int n, input logic [DW-1:0] init);
        logic [DW-1:0] e;
        e = init;
        for (int i = 0; i < n; i++)
            e = e + ja[i] * jb[i];
        sb_q.push_back(e);
    endtask

    task automatic do_start(input int n, input logic [DW-1:0] init);
        @(negedge clk);
        start    = 1'b1;
        len      = LW'(n);
        init_acc = init;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap_max);
        int waited;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic run_job(input int n, input logic [DW-1:0] init, input int gap_max);
        push_expected(n, init);
        do_start(n, init);
        for (int i = 0; i < n; i++)
            send_beat(ja[i], jb[i], gap_max);
    endtask

    task automatic expect_result(input string tag);
        int            w;
        logic [DW-1:0] e;
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_out_data"}, 32'(out_data), 32'(e));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; init_acc = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_acc", 32'(out_data), 32'd0);

        // Basic product; start presented together with reset release
        ja[0] = 16'd2; jb[0] = 16'd3;
        ja[1] = 16'd4; jb[1] = 16'd1;
        ja[2] = 16'd1; jb[2] = 16'd7;
        sb_q.push_back(16'd22);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; len = 8'd3; init_acc = 16'd5;
        @(posedge clk);
        #1 start = 1'b0;
        check("basic_busy_after_first_edge", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++)
            send_beat(ja[i], jb[i], 0);
`ifndef CONF_INT_DOT_SEQ_SKID_EN
        check("basic_out_valid_latency", 32'(out_valid), 32'd1);
`endif
        expect_result("basic");

        // Zero length
        sb_q.push_back(16'h1234);
        do_start(0, 16'h1234);
        check("zero_out_valid_next_cycle", 32'(out_valid), 32'd1);
`ifndef CONF_INT_DOT_SEQ_SKID_EN
        check("zero_in_ready_low", 32'(in_ready), 32'd0);
`endif
        expect_result("zero");

        // Wrap-around
        ja[0] = 16'd1; jb[0] = 16'd1;
        run_job(1, 16'hFFFF, 0);
        expect_result("wrap");

        // Backpressure with ignored start pulses
        ja[0] = 16'd2; jb[0] = 16'd2;
        ja[1] = 16'd3; jb[1] = 16'd3;
        run_job(2, 16'd0, 1);
        begin
            int w;
            w = 0;
            while (!out_valid && w < 100) begin
                @(negedge clk);
                w++;
            end
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = 1'b1; len = 8'd0; init_acc = 16'h7777;
            @(posedge clk);
            #1 start = 1'b0;
            check("bp_out_data_stable", 32'(out_data), 32'd13);
            check("bp_busy", 32'(busy), 32'd1);
        end
        void'(sb_q.pop_front());
        @(negedge clk);
        out_ready = 1'b1; start = 1'b1; len = 8'd0; init_acc = 16'h7777;
        @(posedge clk);
        #1 out_ready = 1'b0; start = 1'b0;
        check("bp_release_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 check("bp_same_cycle_start_ignored", 32'(out_valid), 32'd0);

        // Reset mid-operation
        for (int i = 0; i < 4; i++) begin
            ja[i] = 16'd1; jb[i] = 16'd1;
        end
        do_start(4, 16'd0);
        send_beat(ja[0], jb[0], 0);
        send_beat(ja[1], jb[1], 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_acc", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ja[0] = 16'd3; jb[0] = 16'd3;
        run_job(1, 16'd0, 0);
        expect_result("after_rst");

`ifdef CONF_INT_DOT_SEQ_SKID_EN
        // Pre-load operands in IDLE with random valid toggling
        ja[0] = 16'd5; jb[0] = 16'd1;
        ja[1] = 16'd6; jb[1] = 16'd2;
        ja[2] = 16'd7; jb[2] = 16'd3;
        ja[3] = 16'd8; jb[3] = 16'd4;
        push_expected(4, 16'd1);
        begin
            int   got;
            int   guard;
            logic rdy;
            got   = 0;
            guard = 0;
            while (got < 2 && guard < 200) begin
                @(negedge clk);
                in_valid = 1'($urandom_range(0, 1));
                in_a     = ja[got];
                in_b     = jb[got];
                rdy      = in_ready;
                @(posedge clk);
                if (in_valid && rdy)
                    got++;
                #1 in_valid = 1'b0;
                guard++;
            end
            check("skid_preload_count", 32'(got), 32'd2);
        end
        check("skid_full_in_ready", 32'(in_ready), 32'd0);
        check("skid_idle_busy", 32'(busy), 32'd0);
        do_start(4, 16'd1);
        send_beat(ja[2], jb[2], 2);
        send_beat(ja[3], jb[3], 2);
        expect_result("skid_preload");
`endif

        // Random jobs with random gaps
        for (int j = 0; j < 6; j++) begin
            int n;
            logic [DW-1:0] init;
            n    = $urandom_range(1, 6);
            init = DW'($urandom);
            for (int i = 0; i < n; i++) begin
                ja[i] = DW'($urandom);
                jb[i] = DW'($urandom);
            end
            run_job(n, init, 2);
            expect_result("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
